// File: rtl/echo_indication_serializer.sv
// Serialises Echo heard(v) indications into 5-byte frames (METHOD_ID, then v LSB first)
// on a byte-wide ENA/RDY port, with a small FIFO absorbing transport back-pressure.
module echo_indication_serializer #(
  parameter int          DEPTH     = 2,
  parameter logic [7:0]  METHOD_ID = 8'h01
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        heard__ENA,
  input  logic [31:0] heard_v,
  output logic        heard__RDY,
  output logic        out__ENA,
  output logic [7:0]  out_v,
  output logic        out_last,
  input  logic        out__RDY,
  output logic [15:0] msg_count
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
  localparam logic [2:0]  C_LAST = 3'd4;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic [31:0]   r_hold;
  logic [31:0]   w_hold_nxt;
  logic [15:0]   r_msg_count;

  logic          w_push;
  logic          w_pop;
  logic          w_xfer;
  logic          w_fifo_nonempty;
  logic          w_frame_done;

  // Readiness comes from the registered count only: a full FIFO never bypasses to hold.
  assign w_fifo_nonempty = (r_count != '0);
  assign heard__RDY      = nRST & (r_count != C_FULL);
  assign w_push          = heard__ENA & heard__RDY;
  assign w_xfer          = nRST & (r_state == ST_SEND) & out__RDY;
  assign w_frame_done    = w_xfer & (r_idx == C_LAST);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latches).
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop       = 1'b1;
          w_hold_nxt  = r_mem[r_rd_ptr];
          w_idx_nxt   = 3'd0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          if (r_idx != C_LAST) begin
            w_idx_nxt = r_idx + 3'd1;
          end else if (w_fifo_nonempty) begin
            // Chain straight into the next frame so sustained traffic has no bubble.
            w_pop      = 1'b1;
            w_hold_nxt = r_mem[r_rd_ptr];
            w_idx_nxt  = 3'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!nRST) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= heard_v;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_msg_count <= '0;
    end else if (w_frame_done) begin
      r_msg_count <= r_msg_count + 16'd1;
    end
  end

  always_comb begin
    out_v = METHOD_ID;
    unique case (r_idx)
      3'd1:    out_v = r_hold[7:0];
      3'd2:    out_v = r_hold[15:8];
      3'd3:    out_v = r_hold[23:16];
      3'd4:    out_v = r_hold[31:24];
      default: out_v = METHOD_ID;
    endcase
  end

  assign out__ENA  = w_xfer;
  assign out_last  = nRST & (r_state == ST_SEND) & (r_idx == C_LAST);
  assign msg_count = r_msg_count;

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Bench for echo_indication_serializer: a byte-stream model built from accepted heard calls
// is compared on every cycle, alongside directed latency, back-pressure, reset and wrap checks.
module tb_echo_indication_serializer;

  localparam int         DEPTH = 2;
  localparam logic [7:0] MID   = 8'h01;

  logic        CLK        = 1'b0;
  logic        nRST       = 1'b0;
  logic        heard__ENA = 1'b0;
  logic [31:0] heard_v    = '0;
  logic        out__RDY   = 1'b0;
  logic        heard__RDY;
  logic        out__ENA;
  logic [7:0]  out_v;
  logic        out_last;
  logic [15:0] msg_count;

  echo_indication_serializer #(.DEPTH(DEPTH), .METHOD_ID(MID)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .heard__ENA (heard__ENA),
    .heard_v    (heard_v),
    .heard__RDY (heard__RDY),
    .out__ENA   (out__ENA),
    .out_v      (out_v),
    .out_last   (out_last),
    .out__RDY   (out__RDY),
    .msg_count  (msg_count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected byte stream: each accepted call contributes header + 4 LE bytes.
  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_byte_t;

  exp_byte_t   exp_q[$];
  logic [15:0] frames_done = '0;
  logic [15:0] base        = '0;
  bit          stall_check = 1'b0;

  always @(negedge CLK) begin
    exp_byte_t e;
    if (!nRST) begin
      exp_q.delete();
      frames_done = '0;
    end else begin
      check("msg_count", msg_count, 32'(16'(frames_done + base)));
      if (out__ENA) begin
        if (exp_q.size() == 0) begin
          check("spurious_byte", out__ENA, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_v", out_v, e.b);
          check("out_last", out_last, e.last);
          if (e.last) frames_done = frames_done + 16'd1;
        end
      end else if (stall_check && !out__RDY && exp_q.size() != 0) begin
        check("stall_out_v", out_v, exp_q[0].b);
      end
      if (heard__ENA && heard__RDY) begin
        for (int k = 0; k < 5; k++) begin
          e.b    = (k == 0) ? MID : heard_v[8*(k-1) +: 8];
          e.last = (k == 4);
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] v);
    int g = 0;
    while (!heard__RDY && g < 50) begin
      tick();
      g++;
    end
    if (g == 50) check("heard_rdy_timeout", heard__RDY, 1);
    heard__ENA = 1'b1;
    heard_v    = v;
    tick();
    heard__ENA = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b2b [10];
    int acc;
    b2b = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00};

    // Reset behaviour
    nRST     = 1'b0;
    out__RDY = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    check("rst_heard_rdy", heard__RDY, 0);
    check("rst_out_ena", out__ENA, 0);
    check("rst_out_last", out_last, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("post_rst_heard_rdy", heard__RDY, 1);
    check("post_rst_msg_count", msg_count, 0);
    check("post_rst_out_ena", out__ENA, 0);

    // Single message and latency: heard at N, header at N+2, last at N+6
    @(posedge CLK); #1;
    heard__ENA = 1'b1;
    heard_v    = 32'hDEADBEEF;
    @(negedge CLK);
    @(posedge CLK); #1;
    heard__ENA = 1'b0;
    @(negedge CLK);
    check("lat_n1_idle", out__ENA, 0);
    @(negedge CLK);
    check("lat_n2_ena", out__ENA, 1);
    check("lat_n2_header", out_v, 8'h01);
    check("lat_n2_not_last", out_last, 0);
    repeat (3) @(negedge CLK);
    @(negedge CLK);
    check("lat_n6_byte", out_v, 8'hDE);
    check("lat_n6_last", out_last, 1);
    @(negedge CLK);
    check("single_msg_count", msg_count, 1);
    check("single_idle", out__ENA, 0);

    // Back-to-back: ten consecutive byte cycles, no gap
    @(posedge CLK); #1;
    heard__ENA = 1'b1;
    heard_v    = 32'h00000001;
    tick();
    heard_v    = 32'h00000002;
    tick();
    heard__ENA = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("b2b_ena", out__ENA, 1);
      check("b2b_byte", out_v, b2b[i]);
    end
    @(negedge CLK);
    check("b2b_msg_count", msg_count, 3);

    // Stall: out__RDY toggles during a frame
    @(posedge CLK); #1;
    send(32'hCAFEF00D);
    tick();
    stall_check = 1'b1;
    out__RDY = 1'b0; tick();
    check("stall_no_ena", out__ENA, 0);
    out__RDY = 1'b0; tick();
    out__RDY = 1'b1; tick();
    out__RDY = 1'b0; tick();
    out__RDY = 1'b1; tick();
    out__RDY = 1'b0; tick();
    out__RDY = 1'b1;
    repeat (8) tick();
    stall_check = 1'b0;
    check("stall_msg_count", msg_count, 4);

    // Full: DEPTH+1 calls accepted while transport is blocked
    out__RDY = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (heard__RDY) begin
        heard__ENA = 1'b1;
        heard_v    = 32'h10000000 + 32'(acc);
        acc++;
      end else begin
        heard__ENA = 1'b0;
      end
      tick();
    end
    heard__ENA = 1'b0;
    check("full_accepts", acc, DEPTH + 1);
    check("full_rdy_low", heard__RDY, 0);
    repeat (4) tick();
    check("full_rdy_still_low", heard__RDY, 0);
    out__RDY = 1'b1;
    repeat (20) tick();
    check("full_drain_count", msg_count, 7);
    check("full_rdy_back", heard__RDY, 1);

    // Reset mid-frame with a queued entry
    send(32'h11223344);
    send(32'h55667788);
    tick();
    tick();
    nRST = 1'b0;
    @(negedge CLK);
    check("midrst_out_ena", out__ENA, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_heard_rdy", heard__RDY, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("midrst_rdy_after", heard__RDY, 1);
    check("midrst_msg_count", msg_count, 0);
    check("midrst_no_leftover", out__ENA, 0);
    @(posedge CLK); #1;
    send(32'h0A0B0C0D);
    tick();
    @(negedge CLK);
    check("midrst_clean_hdr_ena", out__ENA, 1);
    check("midrst_clean_hdr", out_v, 8'h01);
    repeat (8) tick();
    check("midrst_frame_count", msg_count, 1);

    // Counter wrap via hierarchical preload
    dut.r_msg_count = 16'hFFFF;
    base = 16'hFFFF - frames_done;
    @(negedge CLK);
    check("wrap_preload", msg_count, 16'hFFFF);
    @(posedge CLK); #1;
    send(32'h89ABCDEF);
    repeat (8) tick();
    check("wrap_zero", msg_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
